// File: rtl/ddr3_port_pkg.sv
// Shared types and constants for the DDR3 user-port responder.
package ddr3_port_pkg;

  localparam int unsigned APP_CMD_W = 3;

  localparam logic [APP_CMD_W-1:0] APP_CMD_READ  = 3'b001;
  localparam logic [APP_CMD_W-1:0] APP_CMD_WRITE = 3'b000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CMD  = 3'd1,
    RD_WAIT = 3'd2,
    RD_RSP  = 3'd3,
    WR_CMD  = 3'd4,
    WR_DATA = 3'd5
  } port_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/level flags.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             push_ok_c;
  logic             pop_ok_c;
  logic [PTR_W:0]   level_next_c;

  assign push_ok_c    = push && !full;
  assign pop_ok_c     = pop && !empty;
  assign level_next_c = level + LVL_W'(push_ok_c) - LVL_W'(pop_ok_c);
  assign rdata        = mem[rd_ptr[PTR_W-1:0]];

  // Storage array; no reset needed, validity is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (push_ok_c) begin
      mem[wr_ptr[PTR_W-1:0]] <= wdata;
    end
  end

  // Pointers and registered occupancy flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + LVL_W'(1);
      if (pop_ok_c)  rd_ptr <= rd_ptr + LVL_W'(1);
      level <= level_next_c;
      full  <= (level_next_c == LVL_W'(DEPTH));
      empty <= (level_next_c == '0);
    end
  end

endmodule

// File: rtl/ddr3_port_responder.sv
// Bridges controller read requests / result writes onto a DDR3 app_* user port.
module ddr3_port_responder #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 28,
  parameter int unsigned WR_FIFO_DEPTH  = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic                      req_rd_en,
  input  logic                      req_we,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic                      req_wvalid,
  output logic                      wr_full,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic                      rsp_valid,
  output logic                      busy,
  output logic [MEM_ADDR_WIDTH-1:0] app_addr,
  output logic [2:0]                app_cmd,
  output logic                      app_en,
  input  logic                      app_rdy,
  output logic [DATA_WIDTH-1:0]     app_wdf_data,
  output logic                      app_wdf_wren,
  output logic                      app_wdf_end,
  input  logic                      app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]     app_rd_data,
  input  logic                      app_rd_data_valid
);

  import ddr3_port_pkg::*;

  localparam int unsigned ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned LVL_W   = $clog2(WR_FIFO_DEPTH) + 1;

  port_state_t              state_q, state_d;
  logic [ADDR_WIDTH-1:0]    rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0]    last_addr_q, last_addr_d;
  logic                     last_valid_q, last_valid_d;
  logic                     cmd_done_q, cmd_done_d;
  logic                     data_done_q, data_done_d;

  logic [MEM_ADDR_WIDTH-1:0] app_addr_d;
  logic [2:0]                app_cmd_d;
  logic                      app_en_d;
  logic [DATA_WIDTH-1:0]     app_wdf_data_d;
  logic                      app_wdf_wren_d;
  logic [DATA_WIDTH-1:0]     rsp_data_d;
  logic                      rsp_valid_d;
  logic                      busy_d;

  logic                      fifo_push_c;
  logic                      fifo_pop_c;
  logic [ENTRY_W-1:0]        fifo_rdata;
  logic                      fifo_empty;
  logic [LVL_W-1:0]          fifo_level;
  logic [LVL_W-1:0]          level_next_c;
  logic [ENTRY_W-1:0]        wr_entry_c;
  logic [ADDR_WIDTH-1:0]     wr_addr_c;
  logic [DATA_WIDTH-1:0]     wr_data_c;
  logic                      cmd_acc_c;
  logic                      dat_acc_c;
  logic                      rd_new_c;
  logic                      unused_wr_addr_c;

  // Write buffer holding {byte address, data} per result word.
  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (WR_FIFO_DEPTH)
  ) u_wr_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push_c),
    .wdata ({req_addr, req_wdata}),
    .pop   (fifo_pop_c),
    .rdata (fifo_rdata),
    .full  (wr_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign fifo_push_c = req_wvalid && !wr_full;
  // An empty FIFO being pushed this cycle forwards the incoming entry as the head.
  assign wr_entry_c  = fifo_empty ? {req_addr, req_wdata} : fifo_rdata;
  assign wr_addr_c   = wr_entry_c[ENTRY_W-1:DATA_WIDTH];
  assign wr_data_c   = wr_entry_c[DATA_WIDTH-1:0];
  assign unused_wr_addr_c = ^wr_addr_c;

  assign cmd_acc_c   = app_en && app_rdy;
  assign dat_acc_c   = app_wdf_wren && app_wdf_rdy;
  assign rd_new_c    = req_rd_en && !req_we && (!last_valid_q || (req_addr != last_addr_q));
  assign app_wdf_end = app_wdf_wren;

  // Next-state and next-output logic; every app_*/rsp_* output is registered from here.
  always_comb begin
    state_d        = state_q;
    rd_addr_d      = rd_addr_q;
    last_addr_d    = last_addr_q;
    last_valid_d   = last_valid_q;
    cmd_done_d     = cmd_done_q;
    data_done_d    = data_done_q;
    app_addr_d     = app_addr;
    app_cmd_d      = app_cmd;
    app_en_d       = app_en;
    app_wdf_data_d = app_wdf_data;
    app_wdf_wren_d = app_wdf_wren;
    rsp_data_d     = rsp_data;
    rsp_valid_d    = 1'b0;
    fifo_pop_c     = 1'b0;
    level_next_c   = '0;
    busy_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty || fifo_push_c) begin
          state_d        = WR_CMD;
          app_en_d       = 1'b1;
          app_cmd_d      = APP_CMD_WRITE;
          app_wdf_wren_d = 1'b1;
          app_addr_d     = wr_addr_c[MEM_ADDR_WIDTH+1:2];
          app_wdf_data_d = wr_data_c;
          cmd_done_d     = 1'b0;
          data_done_d    = 1'b0;
        end else if (rd_new_c) begin
          state_d    = RD_CMD;
          rd_addr_d  = req_addr;
          app_en_d   = 1'b1;
          app_cmd_d  = APP_CMD_READ;
          app_addr_d = req_addr[MEM_ADDR_WIDTH+1:2];
        end
      end
      RD_CMD: begin
        app_en_d = 1'b1;
        if (cmd_acc_c) begin
          app_en_d = 1'b0;
          state_d  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (app_rd_data_valid) begin
          rsp_data_d  = app_rd_data;
          rsp_valid_d = 1'b1;
          state_d     = RD_RSP;
        end
      end
      RD_RSP: begin
        last_addr_d  = rd_addr_q;
        last_valid_d = 1'b1;
        state_d      = IDLE;
      end
      WR_CMD: begin
        cmd_done_d  = cmd_done_q || cmd_acc_c;
        data_done_d = data_done_q || dat_acc_c;
        if (cmd_done_d && data_done_d) begin
          fifo_pop_c     = 1'b1;
          last_valid_d   = 1'b0;
          app_en_d       = 1'b0;
          app_wdf_wren_d = 1'b0;
          state_d        = IDLE;
        end else if (cmd_done_d) begin
          app_en_d       = 1'b0;
          app_wdf_wren_d = 1'b1;
          state_d        = WR_DATA;
        end else begin
          app_en_d       = 1'b1;
          app_wdf_wren_d = !data_done_d;
        end
      end
      WR_DATA: begin
        app_wdf_wren_d = 1'b1;
        if (dat_acc_c) begin
          fifo_pop_c     = 1'b1;
          last_valid_d   = 1'b0;
          app_wdf_wren_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    level_next_c = fifo_level + LVL_W'(fifo_push_c) - LVL_W'(fifo_pop_c);
    busy_d       = (state_d != IDLE) || (level_next_c != '0);
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rd_addr_q    <= '0;
      last_addr_q  <= '0;
      last_valid_q <= 1'b0;
      cmd_done_q   <= 1'b0;
      data_done_q  <= 1'b0;
      app_addr     <= '0;
      app_cmd      <= '0;
      app_en       <= 1'b0;
      app_wdf_data <= '0;
      app_wdf_wren <= 1'b0;
      rsp_data     <= '0;
      rsp_valid    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      last_addr_q  <= last_addr_d;
      last_valid_q <= last_valid_d;
      cmd_done_q   <= cmd_done_d;
      data_done_q  <= data_done_d;
      app_addr     <= app_addr_d;
      app_cmd      <= app_cmd_d;
      app_en       <= app_en_d;
      app_wdf_data <= app_wdf_data_d;
      app_wdf_wren <= app_wdf_wren_d;
      rsp_data     <= rsp_data_d;
      rsp_valid    <= rsp_valid_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_ddr3_port_responder.sv
// Bench for ddr3_port_responder: memory-side responder model plus scoreboarded reads/writes.
module tb_ddr3_port_responder;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned MW  = 28;
  localparam int unsigned DEP = 8;
  localparam int          LAT = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] req_addr;
  logic          req_rd_en;
  logic          req_we;
  logic [DW-1:0] req_wdata;
  logic          req_wvalid;
  logic          wr_full;
  logic [DW-1:0] rsp_data;
  logic          rsp_valid;
  logic          busy;
  logic [MW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic          app_rdy;
  logic [DW-1:0] app_wdf_data;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;

  ddr3_port_responder #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .MEM_ADDR_WIDTH (MW),
    .WR_FIFO_DEPTH  (DEP)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .req_addr          (req_addr),
    .req_rd_en         (req_rd_en),
    .req_we            (req_we),
    .req_wdata         (req_wdata),
    .req_wvalid        (req_wvalid),
    .wr_full           (wr_full),
    .rsp_data          (rsp_data),
    .rsp_valid         (rsp_valid),
    .busy              (busy),
    .app_addr          (app_addr),
    .app_cmd           (app_cmd),
    .app_en            (app_en),
    .app_rdy           (app_rdy),
    .app_wdf_data      (app_wdf_data),
    .app_wdf_wren      (app_wdf_wren),
    .app_wdf_end       (app_wdf_end),
    .app_wdf_rdy       (app_wdf_rdy),
    .app_rd_data       (app_rd_data),
    .app_rd_data_valid (app_rd_data_valid)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Monitor-owned observation counters and queues.
  int rd_cmd_count  = 0;
  int wr_cmd_count  = 0;
  int wdata_count   = 0;
  int wr_done_count = 0;
  int rsp_count     = 0;
  int rd_cnt        = 0;
  logic [MW-1:0]    rd_word;
  logic [DW-1:0]    mem_model [logic [MW-1:0]];
  logic [MW-1:0]    obs_cmd_q [$];
  logic [DW-1:0]    obs_dat_q [$];
  logic [MW+DW-1:0] obs_wr_q  [$];
  logic [DW-1:0]    obs_rsp_q [$];

  // Expected results, pushed by the tests as stimulus is driven.
  logic [MW+DW-1:0] exp_wr_q  [$];
  logic [DW-1:0]    exp_rsp_q [$];

  function automatic logic [DW-1:0] mem_read(input logic [MW-1:0] w);
    if (mem_model.exists(w)) return mem_model[w];
    if (w == 28'h10) return 32'hDEADBEEF;
    return {4'hC, w};
  endfunction

  // Memory model and handshake monitor, evaluated mid-cycle on the falling edge.
  always @(negedge clock) begin
    logic [MW-1:0] a;
    logic [DW-1:0] d;
    app_rd_data_valid = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt = rd_cnt - 1;
      if (rd_cnt == 0) begin
        app_rd_data_valid = 1'b1;
        app_rd_data       = mem_read(rd_word);
      end
    end
    if (rsp_valid) begin
      rsp_count++;
      obs_rsp_q.push_back(rsp_data);
    end
    if (app_en && app_rdy && app_cmd == 3'b001) begin
      rd_cmd_count++;
      rd_word = app_addr;
      rd_cnt  = LAT;
    end
    if (app_en && app_rdy && app_cmd == 3'b000) begin
      wr_cmd_count++;
      obs_cmd_q.push_back(app_addr);
    end
    if (app_wdf_wren && app_wdf_rdy) begin
      wdata_count++;
      obs_dat_q.push_back(app_wdf_data);
    end
    while (obs_cmd_q.size() != 0 && obs_dat_q.size() != 0) begin
      a = obs_cmd_q.pop_front();
      d = obs_dat_q.pop_front();
      mem_model[a] = d;
      wr_done_count++;
      obs_wr_q.push_back({a, d});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req_addr = '0; req_rd_en = 1'b0; req_we = 1'b0;
    req_wdata = '0; req_wvalid = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    step(3);
    checks++;
    if ({app_en, app_wdf_wren, app_wdf_end, rsp_valid, busy, wr_full} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000", {app_en, app_wdf_wren, app_wdf_end, rsp_valid, busy, wr_full});
    end
    checks++;
    if ({app_addr, app_cmd, rsp_data, app_wdf_data} !== '0) begin
      errors++; $display("FAIL reset_data: addr=%h cmd=%b rsp=%h wdf=%h want all 0", app_addr, app_cmd, rsp_data, app_wdf_data);
    end
    reset = 1'b1;
    step(2);
    checks++;
    if (busy !== 1'b0 || app_en !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b app_en=%b want 0 0", busy, app_en);
    end
  endtask

  task automatic test_read();
    logic [DW-1:0] got;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    req_addr = 32'h40; req_we = 1'b0; req_rd_en = 1'b1;
    exp_rsp_q.push_back(32'hDEADBEEF);
    step(1);
    checks++;
    if (app_en !== 1'b1 || app_addr !== 28'h10 || app_cmd !== 3'b001) begin
      errors++; $display("FAIL read_cmd: en=%b addr=%h cmd=%b want 1 0000010 001", app_en, app_addr, app_cmd);
    end
    for (int c = 2; c <= 8; c++) begin
      step(1);
      checks++;
      if (rsp_valid !== (c == 6)) begin
        errors++; $display("FAIL read_latency: cycle %0d rsp_valid=%b want %b", c, rsp_valid, (c == 6));
      end
    end
    while (obs_rsp_q.size() != 0) begin
      got = obs_rsp_q.pop_front();
      checks++;
      if (exp_rsp_q.size() == 0) begin
        errors++; $display("FAIL read_data: unexpected response %h", got);
      end else if (got !== exp_rsp_q[0]) begin
        errors++; $display("FAIL read_data: got %h want %h", got, exp_rsp_q[0]);
        void'(exp_rsp_q.pop_front());
      end else begin
        void'(exp_rsp_q.pop_front());
      end
    end
  endtask

  task automatic test_dup_addr();
    int base;
    logic [DW-1:0] got;
    base = rd_cmd_count;
    step(10);
    checks++;
    if (rd_cmd_count - base != 0) begin
      errors++; $display("FAIL dup_addr_held: %0d extra read commands want 0", rd_cmd_count - base);
    end
    req_addr = 32'h44;
    exp_rsp_q.push_back(32'hC000_0011);
    step(1);
    checks++;
    if (app_en !== 1'b1 || app_addr !== 28'h11 || app_cmd !== 3'b001) begin
      errors++; $display("FAIL new_addr_cmd: en=%b addr=%h cmd=%b want 1 0000011 001", app_en, app_addr, app_cmd);
    end
    for (int i = 0; i < 20 && obs_rsp_q.size() == 0; i++) step(1);
    req_rd_en = 1'b0;
    step(2);
    checks++;
    if (obs_rsp_q.size() == 0) begin
      errors++; $display("FAIL new_addr_rsp: no response within budget want 1");
    end
    while (obs_rsp_q.size() != 0) begin
      got = obs_rsp_q.pop_front();
      checks++;
      if (exp_rsp_q.size() == 0) begin
        errors++; $display("FAIL new_addr_data: unexpected response %h", got);
      end else if (got !== exp_rsp_q[0]) begin
        errors++; $display("FAIL new_addr_data: got %h want %h", got, exp_rsp_q[0]);
        void'(exp_rsp_q.pop_front());
      end else begin
        void'(exp_rsp_q.pop_front());
      end
    end
    checks++;
    if (rd_cmd_count - base != 1) begin
      errors++; $display("FAIL new_addr_count: %0d read commands want 1", rd_cmd_count - base);
    end
  endtask

  task automatic test_fifo_full();
    int base_done, base_cmd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [MW+DW-1:0] got;
    base_done = wr_done_count; base_cmd = wr_cmd_count;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      a = 32'h200 + AW'(4 * k);
      d = 32'h1000 + DW'(k);
      req_addr = a; req_wdata = d; req_wvalid = 1'b1;
      exp_wr_q.push_back({a[MW+1:2], d});
      checks++;
      if (wr_full !== 1'b0) begin
        errors++; $display("FAIL wr_full_early: before push %0d wr_full=%b want 0", k, wr_full);
      end
      step(1);
    end
    checks++;
    if (wr_full !== 1'b1) begin
      errors++; $display("FAIL wr_full_set: got %b want 1", wr_full);
    end
    req_addr = 32'h2F0; req_wdata = 32'h0BAD;
    step(1);
    req_wvalid = 1'b0;
    checks++;
    if (wr_full !== 1'b1 || busy !== 1'b1 || app_en !== 1'b1 || app_addr !== 28'h80 || app_wdf_data !== 32'h1000) begin
      errors++; $display("FAIL wr_stall: full=%b busy=%b en=%b addr=%h wdf=%h want 1 1 1 0000080 00001000", wr_full, busy, app_en, app_addr, app_wdf_data);
    end
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    for (int i = 0; i < 60 && (wr_done_count - base_done) < 8; i++) step(1);
    step(4);
    checks++;
    if (wr_cmd_count - base_cmd != 8 || wr_done_count - base_done != 8) begin
      errors++; $display("FAIL wr_drain_count: cmds=%0d writes=%0d want 8 8", wr_cmd_count - base_cmd, wr_done_count - base_done);
    end
    checks++;
    if (wr_full !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL wr_drained: full=%b busy=%b want 0 0", wr_full, busy);
    end
    while (obs_wr_q.size() != 0) begin
      got = obs_wr_q.pop_front();
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++; $display("FAIL wr_order: unexpected write %h", got);
      end else if (got !== exp_wr_q[0]) begin
        errors++; $display("FAIL wr_order: got %h want %h", got, exp_wr_q[0]);
        void'(exp_wr_q.pop_front());
      end else begin
        void'(exp_wr_q.pop_front());
      end
    end
  endtask

  task automatic test_write_then_read();
    int base_done;
    bit seen_rd;
    logic [DW-1:0] got_d;
    logic [MW+DW-1:0] got_w;
    base_done = wr_done_count; seen_rd = 1'b0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    req_addr = 32'h100; req_wdata = 32'h5A; req_wvalid = 1'b1;
    exp_wr_q.push_back({28'h40, 32'h5A});
    step(1);
    req_wvalid = 1'b0; req_rd_en = 1'b1; req_we = 1'b0;
    exp_rsp_q.push_back(32'h5A);
    for (int i = 0; i < 30 && obs_rsp_q.size() == 0; i++) begin
      if (!seen_rd && app_en && app_cmd == 3'b001) begin
        seen_rd = 1'b1;
        checks++;
        if (wr_done_count - base_done != 1 || app_addr !== 28'h40) begin
          errors++; $display("FAIL raw_order: writes done=%0d addr=%h at read cmd want 1 0000040", wr_done_count - base_done, app_addr);
        end
      end
      step(1);
    end
    req_rd_en = 1'b0;
    step(2);
    checks++;
    if (!seen_rd || obs_rsp_q.size() == 0) begin
      errors++; $display("FAIL raw_done: read cmd seen=%0d responses=%0d want 1 1", seen_rd, obs_rsp_q.size());
    end
    while (obs_rsp_q.size() != 0) begin
      got_d = obs_rsp_q.pop_front();
      checks++;
      if (exp_rsp_q.size() == 0) begin
        errors++; $display("FAIL raw_data: unexpected response %h", got_d);
      end else if (got_d !== exp_rsp_q[0]) begin
        errors++; $display("FAIL raw_data: got %h want %h", got_d, exp_rsp_q[0]);
        void'(exp_rsp_q.pop_front());
      end else begin
        void'(exp_rsp_q.pop_front());
      end
    end
    while (obs_wr_q.size() != 0) begin
      got_w = obs_wr_q.pop_front();
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++; $display("FAIL raw_write: unexpected write %h", got_w);
      end else if (got_w !== exp_wr_q[0]) begin
        errors++; $display("FAIL raw_write: got %h want %h", got_w, exp_wr_q[0]);
        void'(exp_wr_q.pop_front());
      end else begin
        void'(exp_wr_q.pop_front());
      end
    end
  endtask

  task automatic test_split_handshake();
    int base_cmd, base_dat;
    logic [MW+DW-1:0] got;
    base_cmd = wr_cmd_count; base_dat = wdata_count;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    req_addr = 32'h300; req_wdata = 32'h77; req_wvalid = 1'b1;
    exp_wr_q.push_back({28'hC0, 32'h77});
    step(1);
    req_wvalid = 1'b0;
    checks++;
    if (app_en !== 1'b1 || app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1 || app_addr !== 28'hC0) begin
      errors++; $display("FAIL split_c1: en=%b wren=%b end=%b addr=%h want 1 1 1 00000c0", app_en, app_wdf_wren, app_wdf_end, app_addr);
    end
    app_rdy = 1'b1;
    step(1);
    app_rdy = 1'b0;
    checks++;
    if (app_en !== 1'b0 || app_wdf_wren !== 1'b1) begin
      errors++; $display("FAIL split_c2: en=%b wren=%b want 0 1", app_en, app_wdf_wren);
    end
    step(1);
    checks++;
    if (app_wdf_wren !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL split_c3: wren=%b busy=%b want 1 1", app_wdf_wren, busy);
    end
    step(1);
    app_wdf_rdy = 1'b1;
    step(1);
    app_wdf_rdy = 1'b0;
    checks++;
    if (app_wdf_wren !== 1'b0 || app_wdf_end !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL split_c5: wren=%b end=%b busy=%b want 0 0 0", app_wdf_wren, app_wdf_end, busy);
    end
    step(3);
    checks++;
    if (wr_cmd_count - base_cmd != 1 || wdata_count - base_dat != 1) begin
      errors++; $display("FAIL split_count: cmds=%0d beats=%0d want 1 1", wr_cmd_count - base_cmd, wdata_count - base_dat);
    end
    while (obs_wr_q.size() != 0) begin
      got = obs_wr_q.pop_front();
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++; $display("FAIL split_write: unexpected write %h", got);
      end else if (got !== exp_wr_q[0]) begin
        errors++; $display("FAIL split_write: got %h want %h", got, exp_wr_q[0]);
        void'(exp_wr_q.pop_front());
      end else begin
        void'(exp_wr_q.pop_front());
      end
    end
  endtask

  task automatic test_reset_mid();
    int base_rsp;
    base_rsp = rsp_count;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    req_addr = 32'h80; req_we = 1'b0; req_rd_en = 1'b1;
    step(1);
    checks++;
    if (app_en !== 1'b1 || app_cmd !== 3'b001 || app_addr !== 28'h20) begin
      errors++; $display("FAIL mid_cmd: en=%b cmd=%b addr=%h want 1 001 0000020", app_en, app_cmd, app_addr);
    end
    step(1);
    req_rd_en = 1'b0;
    step(1);
    reset = 1'b0;
    #1;
    checks++;
    if ({app_en, app_wdf_wren, rsp_valid, busy, wr_full, app_cmd, app_addr, rsp_data, app_wdf_data} !== '0) begin
      errors++; $display("FAIL mid_reset_outs: en=%b wren=%b rv=%b busy=%b addr=%h want all 0", app_en, app_wdf_wren, rsp_valid, busy, app_addr);
    end
    step(1);
    reset = 1'b1;
    for (int c = 5; c <= 10; c++) begin
      step(1);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL stray_valid: cycle %0d rsp_valid=%b want 0", c, rsp_valid);
      end
    end
    checks++;
    if (rsp_count - base_rsp != 0 || busy !== 1'b0 || app_en !== 1'b0) begin
      errors++; $display("FAIL mid_after: rsp=%0d busy=%b en=%b want 0 0 0", rsp_count - base_rsp, busy, app_en);
    end
    while (obs_rsp_q.size() != 0) void'(obs_rsp_q.pop_front());
  endtask

  initial begin
    test_reset();
    test_read();
    test_dup_addr();
    test_fifo_full();
    test_write_then_read();
    test_split_handshake();
    test_reset_mid();
    checks++;
    if (exp_rsp_q.size() != 0 || exp_wr_q.size() != 0) begin
      errors++; $display("FAIL leftovers: responses=%0d writes=%0d still expected want 0 0", exp_rsp_q.size(), exp_wr_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/ddr3_port_responder.md
# ddr3_port_responder

Memory-side endpoint for the processing state controller. Accepts its word-address read requests and result-write strobes, and converts them into commands on a DDR3 memory-controller application interface (app_* handshake). Returns read data as a single-cycle `rsp_valid` pulse. Buffers bursts of network results in a write FIFO. Sits between the top-level processing controller and the DDR3 MIG-style user port.

## Interface
- `ADDR_WIDTH`, 32: controller byte-address width.
- `DATA_WIDTH`, 32: data word width.
- `MEM_ADDR_WIDTH`, 28: app_addr width, in word units.
- `WR_FIFO_DEPTH`, 8: write buffer entries; power of two, ≥2.

Ports:
- `clock` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_addr` in ADDR_WIDTH: byte address from controller; word-aligned.
- `req_rd_en` in 1: controller wants read data at `req_addr`.
- `req_we` in 1: write mode; read requests are ignored while high.
- `req_wdata` in DATA_WIDTH: result word to write.
- `req_wvalid` in 1: push {`req_addr`,`req_wdata`} into the write FIFO.
- `wr_full` out 1: write FIFO full; a push this cycle is dropped.
- `rsp_data` out DATA_WIDTH: read data, valid with `rsp_valid`.
- `rsp_valid` out 1: one-cycle pulse per completed read.
- `busy` out 1: state ≠ IDLE or write FIFO non-empty.
- `app_addr` out MEM_ADDR_WIDTH: equals `req_addr[MEM_ADDR_WIDTH+1:2]` (word address).
- `app_cmd` out 3: 3'b001 = read, 3'b000 = write.
- `app_en` out 1: command valid.
- `app_rdy` in 1: command accepted when `app_en` && `app_rdy`.
- `app_wdf_data` out DATA_WIDTH: write data.
- `app_wdf_wren` out 1: write data valid.
- `app_wdf_end` out 1: tied equal to `app_wdf_wren` (single-beat bursts).
- `app_wdf_rdy` in 1: write data accepted when `app_wdf_wren` && `app_wdf_rdy`.
- `app_rd_data` in DATA_WIDTH: returned read data.
- `app_rd_data_valid` in 1: read data valid strobe.

## Operation
- FSM states: IDLE, RD_CMD, RD_WAIT, RD_RSP, WR_CMD, WR_DATA.
- IDLE arbitration, in priority order:
  - Write FIFO non-empty → WR_CMD.
  - Else `req_rd_en` && !`req_we` && `req_addr` ≠ `last_addr` (or `last_valid`=0) → latch the address, go to RD_CMD.
  - Reads never bypass pending writes; this guarantees read-after-write ordering.
- RD_CMD: `app_en`=1, `app_cmd`=001. On `app_rdy` → RD_WAIT.
- RD_WAIT: on `app_rd_data_valid`, capture `app_rd_data` into `rsp_data` → RD_RSP.
- RD_RSP: `rsp_valid`=1 for exactly one cycle. Set `last_addr`=latched address and `last_valid`=1 → IDLE.
  - The duplicate-address check prevents re-reading while the controller has not yet advanced its counter.
- WR_CMD: drive the FIFO head; `app_en`=1, `app_cmd`=000, `app_wdf_wren`=1.
  - Command and data may be accepted in the same or different cycles; each handshake is tracked by its own done flag.
  - Both accepted → pop FIFO, clear `last_valid`, go to IDLE.
  - Command accepted but data not → WR_DATA.
- WR_DATA: `app_wdf_wren`=1 until `app_wdf_rdy`, then pop FIFO → IDLE.
- Write FIFO:
  - Push when `req_wvalid` && !`wr_full`.
  - Pop on write completion.
  - Simultaneous push and pop when full: the pop frees a slot, but `wr_full` is registered, so that push is still dropped.
  - Pointers are log2(WR_FIFO_DEPTH)+1 bits; they wrap naturally.
- A stray `app_rd_data_valid` outside RD_WAIT is ignored.
- `app_*` outputs are registered; no combinational path from `app_rdy` to `app_en`.

## Timing
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, `last_valid`=0. `app_addr`, `rsp_data`, `app_wdf_data` are 0.
- Reset asserted mid-transaction aborts immediately; FIFO contents are lost; no `rsp_valid` is produced.
- Read latency: request seen in IDLE at cycle N → `app_en` at N+1.
  - With `app_rdy`=1 and memory latency L (cycles from command accept to `app_rd_data_valid`), `rsp_valid` at N+2+L.
- Write: FIFO push at N → `app_en`/`app_wdf_wren` at N+1 if IDLE. One write completes per ≥2 cycles.
- `wr_full` updates the cycle after the push that fills the FIFO.

## Structure
- Package `ddr3_port_pkg`:
  - `APP_CMD_READ`/`APP_CMD_WRITE` constants.
  - `port_state_t` enum (logic [2:0]).
- One sub-module `sync_fifo` (parameterised WIDTH, DEPTH; outputs full/empty) for the write buffer, width ADDR_WIDTH+DATA_WIDTH.
- The rest is a single FSM plus datapath registers.

## Test plan
- Read, `app_rdy`=1, L=4: `req_addr`=0x40, `req_rd_en`=1 at cycle 0.
  - → `app_addr`=0x10, `app_cmd`=001 at cycle 1.
  - → `rsp_valid` single pulse with data 0xDEADBEEF at cycle 6.
- Held address 0x40 for 10 cycles after the response → exactly one read command. Change to 0x44 → second command, `app_addr`=0x11.
- Eight back-to-back `req_wvalid` pushes with `app_rdy`=0 → `wr_full`=1 after the 8th.
  - → A 9th push is dropped.
  - → Releasing `app_rdy`/`app_wdf_rdy` yields 8 writes in FIFO order.
- Write then read: push write 0x100 with data 0x5A, then request read 0x100 → the read command is issued only after the write handshake completes.
- Write handshakes split: `app_rdy` in cycle 1, `app_wdf_rdy` in cycle 4 → exactly one command and one data beat; the FIFO pops at cycle 4.
- Reset low during RD_WAIT → all outputs 0 next edge; a later `app_rd_data_valid` produces no `rsp_valid`.
